elastic_fifo_int16: RTL and testbench
=====================================

// Module: elastic_fifo_int16
// PURPOSE
//  Elastic output buffer placed directly downstream of the fixed-latency delay_INT16_* stages.
//  A delay line cannot stall, so this block absorbs its output into a FIFO and re-emits it under
//  a valid/ready handshake.
//  almost_full is the early stall signal to the scheduler feeding the delay line. It leaves room
//  for every sample already in flight in that line.
//  Overflow is detected, counted and latched; it is never silent.
// PARAMETERS
//  WIDTH        16  data width in bits
//  DEPTH        8   FIFO entries; power of two, >= 2
//  AFULL_SLACK  4   free slots reserved for in-flight samples; equals upstream delay latency; < DEPTH
// PORTS
//  clock        in   1                rising-edge clock
//  reset        in   1                synchronous, active-high reset
//  in_valid     in   1                input sample present this cycle (no ready; cannot be stalled)
//  in           in   WIDTH            input sample
//  almost_full  out  1                level >= DEPTH-AFULL_SLACK; upstream stops issuing new samples
//  out_valid    out  1                out holds the oldest stored sample
//  out_ready    in   1                consumer accepts out this cycle
//  out          out  WIDTH            FIFO head; forced to 0 when out_valid=0
//  level        out  $clog2(DEPTH)+1  entries currently stored, 0..DEPTH
//  overflow     out  1                sticky: a sample was dropped since reset
//  drop_count   out  8                dropped samples; saturates at 255
// BEHAVIOUR
//  - Reset, on a clock edge with reset=1:
//    - wr_ptr, rd_ptr, level, drop_count clear to 0; overflow clears to 0.
//    - Outputs after reset: out_valid=0, out=0, almost_full=0.
//    - Storage contents are don't-care.
//    - Reset overrides any push or pop in the same cycle; in-flight data is discarded.
//  - Events each cycle:
//    - pop  = out_valid & out_ready.
//    - push = in_valid & (level<DEPTH | pop).
//    - drop = in_valid & ~push.
//  - Push: mem[wr_ptr]<=in; wr_ptr increments mod DEPTH (natural wrap, no skipped entries).
//  - Pop: rd_ptr increments mod DEPTH.
//  - level next = level + push - pop; push and pop in the same cycle leave level unchanged.
//  - Latency: a sample pushed at edge N appears on out with out_valid=1 after edge N
//    when the FIFO was empty (no same-cycle bypass).
//    Otherwise it appears after all older entries have popped.
//  - out_valid = (level!=0), derived combinationally from registered state.
//    out = mem[rd_ptr] when out_valid, else 0.
//    out and out_valid hold stable while out_valid & ~out_ready.
//  - Full (level=DEPTH) with pop: the incoming sample is accepted and the pop completes.
//  - Full without pop: the sample is dropped.
//    - overflow<=1; drop_count increments, saturating at 255.
//    - level, pointers and stored data are unchanged.
//  - Empty (level=0): out_ready is ignored and no pop occurs.
//  - almost_full is combinational from level.
//    If upstream honours it within AFULL_SLACK cycles, drop never fires.
//  - Ordering is strict FIFO; no sample is duplicated or reordered.
// TESTING
//  1. Reset, then in_valid=1 for one cycle with in=16'h1234, out_ready=0.
//     -> Next cycle out_valid=1, out=16'h1234, level=1.
//     -> out holds until out_ready=1; after that pop, level=0 and out=0.
//  2. Push 8 samples 1..8 with out_ready=0.
//     -> level=8; almost_full asserts once level reaches 4.
//     -> Then out_ready=1 for 8 cycles -> 1..8 emerge in order, level returns to 0.
//  3. FIFO full, then push 16'hAAAA with out_ready=0 -> overflow=1, drop_count=1, level stays 8.
//     -> Pushing 300 more samples the same way -> drop_count saturates at 255.
//  4. FIFO full, then in_valid=1 and out_ready=1 for 20 cycles -> no drops, level stays 8.
//     -> Output order is continuous across the pointer wrap.
//  5. Random in_valid/out_ready for 10k cycles against a scoreboard model.
//     -> Data is bit-exact and in order; level matches the model.
//     -> Zero drops whenever the stimulus obeys almost_full with slack 4.
//  6. reset=1 mid-stream with level=5 and push+pop active.
//     -> Next cycle level=0, out_valid=0, out=0, overflow=0, drop_count=0.

Source files
------------

// File: rtl/elastic_fifo_int16.sv
// Elastic FIFO that absorbs a non-stallable sample stream and re-emits it under valid/ready.
// Samples that arrive while the FIFO is full and not popping are dropped, counted and flagged.
module elastic_fifo_int16 #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned AFULL_SLACK = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in,
   output logic                     almost_full,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [7:0]               drop_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             overflow_q, overflow_d;
   logic [7:0]       drop_count_q, drop_count_d;
   logic             push, pop, drop;

   always_comb begin
      out_valid    = (level_q != '0);
      pop          = out_valid & out_ready;
      // A full FIFO can still accept when the head leaves in the same cycle.
      push         = in_valid & ((level_q < LW'(DEPTH)) | pop);
      drop         = in_valid & ~push;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      level_d = level_q + LW'(push) - LW'(pop);
      if (drop) begin
         overflow_d = 1'b1;
         if (drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
         end
      end
   end

   always_comb begin
      out         = out_valid ? mem_q[rd_ptr_q] : '0;
      almost_full = (level_q >= LW'(DEPTH - AFULL_SLACK));
      level       = level_q;
      overflow    = overflow_q;
      drop_count  = drop_count_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   // Storage has no reset; a push coinciding with reset is discarded.
   always_ff @(posedge clock) begin
      if (push && !reset) begin
         mem_q[wr_ptr_q] <= in;
      end
   end

endmodule

// File: tb/tb_elastic_fifo_int16.sv
// Directed and scoreboard-checked bench for elastic_fifo_int16.
module tb_elastic_fifo_int16;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] din = '0;
   logic        almost_full;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] dout;
   logic [3:0]  level;
   logic        overflow;
   logic [7:0]  drop_count;

   int vectors = 0;
   int miscompares = 0;

   elastic_fifo_int16 dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .in          (din),
      .almost_full (almost_full),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out         (dout),
      .level       (level),
      .overflow    (overflow),
      .drop_count  (drop_count)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++;
         $display("FAIL rst_out_valid got %b want 0", out_valid); end
      vectors++;
      if (dout !== 16'h0) begin miscompares++; $display("FAIL rst_out got %h want 0000", dout); end
      vectors++;
      if (almost_full !== 1'b0) begin miscompares++;
         $display("FAIL rst_almost_full got %b want 0", almost_full); end
      vectors++;
      if (level !== 4'd0) begin miscompares++; $display("FAIL rst_level got %0d want 0", level); end
      vectors++;
      if (overflow !== 1'b0 || drop_count !== 8'd0) begin miscompares++;
         $display("FAIL rst_overflow got %b/%0d want 0/0", overflow, drop_count); end
   endtask

   task automatic test_single();
      in_valid = 1'b1; din = 16'h1234;
      step();
      in_valid = 1'b0; din = 16'h0;
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (out_valid !== 1'b1 || dout !== 16'h1234 || level !== 4'd1) begin miscompares++;
            $display("FAIL single_hold[%0d] got v=%b out=%h lvl=%0d want v=1 out=1234 lvl=1",
                     k, out_valid, dout, level); end
         step();
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || dout !== 16'h0 || level !== 4'd0) begin miscompares++;
         $display("FAIL single_pop got v=%b out=%h lvl=%0d want v=0 out=0000 lvl=0",
                  out_valid, dout, level); end
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; din = 16'(i);
         step();
         vectors++;
         if (level !== 4'(i) || almost_full !== (i >= 4)) begin miscompares++;
            $display("FAIL fill[%0d] got lvl=%0d af=%b want lvl=%0d af=%b",
                     i, level, almost_full, i, (i >= 4)); end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         vectors++;
         if (out_valid !== 1'b1 || dout !== 16'(i) || level !== 4'(9 - i)) begin miscompares++;
            $display("FAIL drain[%0d] got v=%b out=%h lvl=%0d want v=1 out=%h lvl=%0d",
                     i, out_valid, dout, level, 16'(i), 9 - i); end
         step();
      end
      out_ready = 1'b0;
      vectors++;
      if (level !== 4'd0 || out_valid !== 1'b0 || almost_full !== 1'b0) begin miscompares++;
         $display("FAIL drain_end got lvl=%0d v=%b af=%b want 0/0/0", level, out_valid,
                  almost_full); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; din = 16'h0100 + 16'(i);
         step();
      end
      din = 16'hAAAA;
      step();
      vectors++;
      if (overflow !== 1'b1 || drop_count !== 8'd1 || level !== 4'd8) begin miscompares++;
         $display("FAIL ovf_first got ovf=%b cnt=%0d lvl=%0d want 1/1/8", overflow, drop_count,
                  level); end
      vectors++;
      if (dout !== 16'h0101) begin miscompares++;
         $display("FAIL ovf_head got %h want 0101", dout); end
      for (int i = 0; i < 300; i++) begin
         din = 16'(i);
         step();
      end
      in_valid = 1'b0;
      vectors++;
      if (drop_count !== 8'd255 || level !== 4'd8 || overflow !== 1'b1) begin miscompares++;
         $display("FAIL ovf_sat got cnt=%0d lvl=%0d ovf=%b want 255/8/1", drop_count, level,
                  overflow); end
      vectors++;
      if (dout !== 16'h0101) begin miscompares++;
         $display("FAIL ovf_head_after got %h want 0101", dout); end
   endtask

   task automatic test_full_passthrough();
      logic [15:0] exp_q [$];
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; din = 16'h0100 + 16'(i);
         exp_q.push_back(din);
         step();
      end
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         din = 16'h0200 + 16'(k);
         vectors++;
         if (dout !== exp_q[0] || level !== 4'd8) begin miscompares++;
            $display("FAIL wrap[%0d] got out=%h lvl=%0d want out=%h lvl=8", k, dout, level,
                     exp_q[0]); end
         void'(exp_q.pop_front());
         exp_q.push_back(din);
         step();
      end
      in_valid = 1'b0; out_ready = 1'b0;
      vectors++;
      if (drop_count !== 8'd0 || overflow !== 1'b0 || level !== 4'd8) begin miscompares++;
         $display("FAIL wrap_end got cnt=%0d ovf=%b lvl=%0d want 0/0/8", drop_count, overflow,
                  level); end
   endtask

   task automatic test_random();
      logic [15:0] model_q [$];
      logic        iss_v [4];
      logic [15:0] iss_d [4];
      logic        exp_v, mpop, issue;
      do_reset();
      for (int j = 0; j < 4; j++) begin iss_v[j] = 1'b0; iss_d[j] = '0; end
      for (int c = 0; c < 10000; c++) begin
         in_valid  = iss_v[3];
         din       = iss_d[3];
         out_ready = ($urandom_range(0, 1) == 1);
         exp_v     = (model_q.size() != 0);
         vectors++;
         if (out_valid !== exp_v || level !== 4'(model_q.size())) begin miscompares++;
            $display("FAIL rand_state[%0d] got v=%b lvl=%0d want v=%b lvl=%0d", c, out_valid,
                     level, exp_v, model_q.size()); end
         if (exp_v) begin
            vectors++;
            if (dout !== model_q[0]) begin miscompares++;
               $display("FAIL rand_data[%0d] got %h want %h", c, dout, model_q[0]); end
         end
         mpop = exp_v & out_ready;
         if (mpop) void'(model_q.pop_front());
         if (in_valid && model_q.size() < 8) model_q.push_back(din);
         // Scheduler side: issue only when almost_full is low; samples land 4 cycles later.
         issue = !almost_full && ($urandom_range(0, 3) != 0);
         for (int j = 3; j > 0; j--) begin iss_v[j] = iss_v[j-1]; iss_d[j] = iss_d[j-1]; end
         iss_v[0] = issue;
         iss_d[0] = 16'($urandom);
         step();
      end
      in_valid = 1'b0; out_ready = 1'b0;
      vectors++;
      if (drop_count !== 8'd0 || overflow !== 1'b0) begin miscompares++;
         $display("FAIL rand_drops got cnt=%0d ovf=%b want 0/0", drop_count, overflow); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1; din = 16'h0300 + 16'(i);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      out_ready = 1'b0;
      vectors++;
      if (level !== 4'd5 || overflow !== 1'b1 || drop_count !== 8'd1) begin miscompares++;
         $display("FAIL midrst_pre got lvl=%0d ovf=%b cnt=%0d want 5/1/1", level, overflow,
                  drop_count); end
      in_valid = 1'b1; din = 16'hBEEF; out_ready = 1'b1; reset = 1'b1;
      step();
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      vectors++;
      if (level !== 4'd0 || out_valid !== 1'b0 || dout !== 16'h0) begin miscompares++;
         $display("FAIL midrst_q got lvl=%0d v=%b out=%h want 0/0/0000", level, out_valid,
                  dout); end
      vectors++;
      if (overflow !== 1'b0 || drop_count !== 8'd0) begin miscompares++;
         $display("FAIL midrst_ovf got ovf=%b cnt=%0d want 0/0", overflow, drop_count); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_drain();
      test_overflow();
      test_full_passthrough();
      test_random();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
